snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game sequencer for the snake datapath, clocked on `slow_clk`. It issues the movement strobe, waits for the datapath to settle, then checks the new head against the walls, the food and every body segment. The scan uses one segment read per cycle. From that check it raises `food_eaten` (growth) or ends the game, and it shortens the step period as the score rises. It sits between the button/debounce logic and the snake datapath, whose `directionEnable`, `food_eaten` and `rst` inputs it drives.

## Interface
- `STEP_INIT`, 20: `slow_clk` cycles per move at score 0.
- `STEP_MIN`, 6: floor of the step period.
- `STEP_DEC`, 1: period reduction per food eaten.
- `X_MAX`, 95: largest legal head x.
- `Y_MAX`, 63: largest legal head y.
- `MAX_LENGTH`, 48: largest snake size.

Ports:
- `slow_clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; starts a game from IDLE or DEAD.
- `pause` in 1: one-cycle pulse; toggles RUN/PAUSE.
- `head_x`, `head_y` in 10 each: current head position from the datapath.
- `food_x`, `food_y` in 10 each: current food position.
- `snake_size` in 8: current length; 2..MAX_LENGTH.
- `seg_idx` out 6: segment read index; 0 = tail, `snake_size-1` = head.
- `seg_x`, `seg_y` in 10 each: segment at `seg_idx`, combinational, same cycle.
- `direction_enable` out 1: one-cycle move strobe.
- `food_eaten` out 1: one-cycle growth pulse.
- `snake_rst` out 1: one-cycle datapath reset pulse.
- `game_over` out 1: high while in DEAD.
- `state` out 3: IDLE=0, RUN=1, SETTLE=2, CHECK=3, PAUSE=4, DEAD=5.
- `score` out 8: foods eaten; saturates at 255.
- `step_period` out 8: current period.

## Operation
- Reset values:
  - state IDLE; `step_period`=STEP_INIT.
  - `score`, `seg_idx`, `direction_enable`, `food_eaten`, `snake_rst`, `game_over` all 0.
  - Step counter 0.
- IDLE/DEAD + `start`:
  - `snake_rst` pulses for 1 cycle.
  - `score`←0, `step_period`←STEP_INIT, counter←0; go to RUN.
- RUN:
  - Counter increments each cycle.
  - When counter = `step_period-1`: `direction_enable` pulses for 1 cycle, counter←0, go to SETTLE.
  - `pause` → PAUSE; counter is held.
- PAUSE:
  - `pause` → RUN; counter resumes from its held value.
  - No strobes are issued.
- SETTLE: waits exactly 2 cycles (datapath write, then flatten), then goes to CHECK with `seg_idx`←0.
- CHECK, first cycle: if `head_x`>X_MAX or `head_y`>Y_MAX → DEAD immediately.
- CHECK, scan:
  - One segment per cycle, `seg_idx` 0..`snake_size-2`; the head index is excluded.
  - Any `seg_x`=`head_x` and `seg_y`=`head_y` → DEAD, and the scan aborts.
- CHECK, scan done without collision:
  - If head = food: `food_eaten` pulses for 1 cycle, `score`+1 (saturating), `step_period`←max(`step_period`−STEP_DEC, STEP_MIN).
  - Return to RUN with counter 0.
- DEAD: `game_over`=1; all strobes stay low until `start`.
- Arithmetic:
  - Comparisons are unsigned 10-bit.
  - Period subtraction is done at 9 bits so it cannot underflow before the clamp.

## Timing
- `direction_enable` at edge T; earliest CHECK cycle is T+3.
- Scan length is `snake_size-1` cycles.
- Move-to-move interval is `step_period` + 2 + (`snake_size-1`) + 1 cycles; the counter is frozen outside RUN.
- `food_eaten` is asserted in the final CHECK cycle. At the next edge the datapath grows and the state is RUN.
- Simultaneous events and boundaries:
  - `start` is ignored in RUN, SETTLE, CHECK and PAUSE.
  - `pause` is ignored outside RUN/PAUSE and is dropped, not latched.
  - `start` and `pause` in the same IDLE cycle: start wins.
  - A wall hit takes precedence over food and the scan; a self collision suppresses `food_eaten`.
  - `snake_size`=MAX_LENGTH still pulses `food_eaten`; the datapath ignores it, but `score` still increments.
  - `rst` mid-CHECK returns all outputs to their reset values asynchronously.

## Test plan
- Reset, then `start`: `snake_rst` is 1 for 1 cycle; state=RUN; the first `direction_enable` comes 20 cycles later; state goes SETTLE for 2 cycles, then CHECK.
- `head_x`=96 at CHECK entry: state=DEAD and `game_over`=1 on the next edge; no `food_eaten`.
- Head (10,10), food (10,10), `snake_size`=5, no overlaps: 4 scan cycles (`seg_idx` 0..3), then `food_eaten` 1 cycle, `score`=1, `step_period`=19.
- Same setup but `seg_idx`=2 returns (10,10): DEAD after that cycle; `food_eaten` never asserted; `score` unchanged.
- Eat 20 foods: `step_period` clamps at 6, and the 21st food keeps it at 6.
- `pause` with counter=7: no strobes for 50 cycles; after a second `pause`, `direction_enable` arrives after 12 more cycles.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the snake datapath: paces moves, lets the datapath settle,
// then scans the new head against walls, food and body to grow or end the game.
module snake_game_ctrl #(
    parameter int STEP_INIT  = 20,
    parameter int STEP_MIN   = 6,
    parameter int STEP_DEC   = 1,
    parameter int X_MAX      = 95,
    parameter int Y_MAX      = 63,
    parameter int MAX_LENGTH = 48
) (
    input  logic       slow_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] head_x,
    input  logic [9:0] head_y,
    input  logic [9:0] food_x,
    input  logic [9:0] food_y,
    input  logic [7:0] snake_size,
    output logic [5:0] seg_idx,
    input  logic [9:0] seg_x,
    input  logic [9:0] seg_y,
    output logic       direction_enable,
    output logic       food_eaten,
    output logic       snake_rst,
    output logic       game_over,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic [7:0] step_period
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_PAUSE  = 3'd4,
        S_DEAD   = 3'd5
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_settle, w_settle_nxt;
    logic [5:0] r_seg_idx, w_seg_nxt;
    logic [7:0] r_score, w_score_nxt;
    logic [7:0] r_period, w_period_nxt;

    logic       w_dir_en, w_food_eaten, w_snake_rst;
    logic       w_wall_hit, w_seg_hit, w_food_hit, w_scan_last, w_step_done;
    logic [7:0] w_size_m1;
    logic [8:0] w_period_sub;
    logic [7:0] w_period_dec;

    assign w_wall_hit  = (head_x > 10'(X_MAX)) || (head_y > 10'(Y_MAX));
    assign w_seg_hit   = (seg_x == head_x) && (seg_y == head_y);
    assign w_food_hit  = (food_x == head_x) && (food_y == head_y);
    assign w_size_m1   = snake_size - 8'd1;
    // The head index is never scanned; the length cap bounds the scan if size is corrupt.
    assign w_scan_last = ({2'b00, r_seg_idx} >= w_size_m1) ||
                         ({2'b00, r_seg_idx} >= 8'(MAX_LENGTH - 1));
    assign w_step_done = (r_cnt >= r_period - 8'd1);

    // Ninth bit catches a wrap below zero before the floor clamp is applied.
    assign w_period_sub = {1'b0, r_period} - 9'(STEP_DEC);
    assign w_period_dec = (w_period_sub[8] || (w_period_sub < 9'(STEP_MIN))) ?
                          8'(STEP_MIN) : w_period_sub[7:0];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_settle_nxt = r_settle;
        w_seg_nxt    = r_seg_idx;
        w_score_nxt  = r_score;
        w_period_nxt = r_period;
        w_dir_en     = 1'b0;
        w_food_eaten = 1'b0;
        w_snake_rst  = 1'b0;

        case (r_state)
            S_IDLE, S_DEAD: begin
                if (start) begin
                    w_snake_rst  = 1'b1;
                    w_score_nxt  = 8'd0;
                    w_period_nxt = 8'(STEP_INIT);
                    w_cnt_nxt    = 8'd0;
                    w_seg_nxt    = 6'd0;
                    w_state_nxt  = S_RUN;
                end
            end

            S_RUN: begin
                if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_step_done) begin
                    w_dir_en     = 1'b1;
                    w_cnt_nxt    = 8'd0;
                    w_settle_nxt = 1'b0;
                    w_state_nxt  = S_SETTLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            S_PAUSE: begin
                if (pause) begin
                    w_state_nxt = S_RUN;
                end
            end

            S_SETTLE: begin
                // First cycle covers the datapath write, second its flatten.
                if (r_settle) begin
                    w_settle_nxt = 1'b0;
                    w_seg_nxt    = 6'd0;
                    w_state_nxt  = S_CHECK;
                end else begin
                    w_settle_nxt = 1'b1;
                end
            end

            S_CHECK: begin
                if ((r_seg_idx == 6'd0) && w_wall_hit) begin
                    w_seg_nxt   = 6'd0;
                    w_state_nxt = S_DEAD;
                end else if (w_scan_last) begin
                    if (w_food_hit) begin
                        w_food_eaten = 1'b1;
                        w_score_nxt  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                        w_period_nxt = w_period_dec;
                    end
                    w_seg_nxt   = 6'd0;
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = S_RUN;
                end else if (w_seg_hit) begin
                    w_seg_nxt   = 6'd0;
                    w_state_nxt = S_DEAD;
                end else begin
                    w_seg_nxt = r_seg_idx + 6'd1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_settle  <= 1'b0;
            r_seg_idx <= 6'd0;
            r_score   <= 8'd0;
            r_period  <= 8'(STEP_INIT);
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_settle  <= w_settle_nxt;
            r_seg_idx <= w_seg_nxt;
            r_score   <= w_score_nxt;
            r_period  <= w_period_nxt;
        end
    end

    assign seg_idx          = r_seg_idx;
    assign direction_enable = w_dir_en;
    assign food_eaten       = w_food_eaten;
    assign snake_rst        = w_snake_rst;
    assign game_over        = (r_state == S_DEAD);
    assign state            = r_state;
    assign score            = r_score;
    assign step_period      = r_period;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed vectors, pause/reset sequences,
// and randomized moves scored by a move-level model of the game rules.
module tb_snake_game_ctrl;

    logic       slow_clk = 1'b0;
    logic       rst, start, pause;
    logic [9:0] head_x, head_y, food_x, food_y, seg_x, seg_y;
    logic [7:0] snake_size;
    logic [5:0] seg_idx;
    logic       direction_enable, food_eaten, snake_rst, game_over;
    logic [2:0] state;
    logic [7:0] score, step_period;

    logic [9:0] m_seg_x [0:63];
    logic [9:0] m_seg_y [0:63];

    int n_vec = 0;
    int n_err = 0;
    int exp_score, exp_period;
    bit alive;

    typedef struct {
        int hx, hy, fx, fy, size, coll;
        bit dead, eat;
        int chk;
    } vec_t;
    vec_t tbl [8];

    snake_game_ctrl dut (
        .slow_clk(slow_clk), .rst(rst), .start(start), .pause(pause),
        .head_x(head_x), .head_y(head_y), .food_x(food_x), .food_y(food_y),
        .snake_size(snake_size), .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y),
        .direction_enable(direction_enable), .food_eaten(food_eaten),
        .snake_rst(snake_rst), .game_over(game_over), .state(state),
        .score(score), .step_period(step_period)
    );

    always #5 slow_clk = ~slow_clk;

    assign seg_x = m_seg_x[seg_idx];
    assign seg_y = m_seg_y[seg_idx];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge slow_clk);
        #1;
    endtask

    // Body segments sit far off-board; the head index always mirrors the head.
    task automatic setup(input int hx, hy, fx, fy, size, coll);
        head_x = 10'(hx); head_y = 10'(hy);
        food_x = 10'(fx); food_y = 10'(fy);
        snake_size = 8'(size);
        for (int i = 0; i < 64; i++) begin
            m_seg_x[i] = 10'(500 + i);
            m_seg_y[i] = 10'd500;
        end
        m_seg_x[size-1] = 10'(hx); m_seg_y[size-1] = 10'(hy);
        if (coll >= 0) begin
            m_seg_x[coll] = 10'(hx); m_seg_y[coll] = 10'(hy);
        end
    endtask

    function automatic void predict(input int hx, hy, fx, fy, size, coll,
                                    output bit dead, output bit eat, output int chk);
        bit wall;
        wall = (hx > 95) || (hy > 63);
        dead = wall || (coll >= 0);
        eat  = !dead && (hx == fx) && (hy == fy);
        chk  = wall ? 1 : ((coll >= 0) ? coll + 1 : size);
    endfunction

    task automatic do_start(input bit with_pause);
        start = 1'b1; pause = with_pause;
        #1;
        check("snake_rst_pulse", snake_rst, 1);
        step();
        start = 1'b0; pause = 1'b0;
        check("state_after_start", state, 1);
        check("snake_rst_clear", snake_rst, 0);
        check("score_after_start", score, 0);
        check("period_after_start", step_period, 20);
        exp_score = 0; exp_period = 20; alive = 1'b1;
    endtask

    task automatic finish_move(input int size, input bit dead, input bit eat, input int chk);
        int n_chk = 0;
        int n_eat = 0;
        step();
        check("dir_en_one_cycle", direction_enable, 0);
        check("settle_1", state, 2);
        step();
        check("settle_2", state, 2);
        step();
        check("check_entry", state, 3);
        while (state == 3'd3 && n_chk < 100) begin
            if (n_chk < size - 1) check("seg_idx", seg_idx, n_chk);
            if (food_eaten) n_eat++;
            n_chk++;
            step();
        end
        check("check_cycles", n_chk, chk);
        check("food_eaten_count", n_eat, eat ? 1 : 0);
        if (eat) begin
            exp_score  = (exp_score < 255) ? exp_score + 1 : 255;
            exp_period = (exp_period - 1 < 6) ? 6 : exp_period - 1;
        end
        check("score", score, exp_score);
        check("step_period", step_period, exp_period);
        check("state_after_check", state, dead ? 5 : 1);
        check("game_over", game_over, dead);
        alive = !dead;
    endtask

    task automatic run_move(input int hx, hy, fx, fy, size, coll,
                            input bit dead, input bit eat, input int chk);
        int waited = 0;
        setup(hx, hy, fx, fy, size, coll);
        while (!direction_enable && waited < 400) begin
            step();
            waited++;
        end
        check("dir_latency", waited, exp_period - 1);
        finish_move(size, dead, eat, chk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, waited;
        int hx, hy, fx, fy, size, coll, chk;
        bit dead, eat;

        tbl[0] = '{10, 10, 10, 10,  5, -1, 1'b0, 1'b1,  5};
        tbl[1] = '{10, 10, 10, 10,  5,  2, 1'b1, 1'b0,  3};
        tbl[2] = '{96, 10, 96, 10,  5, -1, 1'b1, 1'b0,  1};
        tbl[3] = '{10, 64, 10, 64,  5, -1, 1'b1, 1'b0,  1};
        tbl[4] = '{95, 63,  0,  0,  2, -1, 1'b0, 1'b0,  2};
        tbl[5] = '{ 0,  0,  0,  0, 48, 46, 1'b1, 1'b0, 47};
        tbl[6] = '{ 5,  7,  5,  8,  3, -1, 1'b0, 1'b0,  3};
        tbl[7] = '{95, 63, 95, 63, 48, -1, 1'b0, 1'b1, 48};

        rst = 1'b1; start = 1'b0; pause = 1'b0;
        setup(0, 0, 0, 0, 2, -1);
        #2;
        check("rst_state", state, 0);
        check("rst_period", step_period, 20);
        check("rst_score", score, 0);
        check("rst_seg_idx", seg_idx, 0);
        check("rst_dir_en", direction_enable, 0);
        check("rst_food_eaten", food_eaten, 0);
        check("rst_snake_rst", snake_rst, 0);
        check("rst_game_over", game_over, 0);
        @(negedge slow_clk);
        rst = 1'b0;
        step();

        // Start and pause together in IDLE: start wins.
        do_start(1'b1);

        // Start ignored in RUN, then pause holds the counter at 7.
        setup(20, 20, 30, 30, 4, -1);
        repeat (3) step();
        start = 1'b1;
        #1;
        check("start_ignored_run", snake_rst, 0);
        step();
        start = 1'b0;
        check("still_run", state, 1);
        repeat (3) step();
        pause = 1'b1;
        #1;
        check("pause_no_strobe", direction_enable, 0);
        step();
        pause = 1'b0;
        check("paused", state, 4);
        n = 0;
        repeat (50) begin
            if (direction_enable) n++;
            step();
        end
        check("pause_strobes", n, 0);
        check("still_paused", state, 4);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("resumed", state, 1);
        waited = 0;
        while (!direction_enable && waited < 100) begin
            step();
            waited++;
        end
        check("resume_latency", waited, 12);
        finish_move(4, 1'b0, 1'b0, 4);

        // Period clamp at the 14th food and score saturation.
        for (int k = 0; k < 260; k++) begin
            run_move(10, 10, 10, 10, 2, -1, 1'b0, 1'b1, 2);
            if (k == 19) check("period_clamp_20", step_period, 6);
            if (k == 20) check("period_clamp_21", step_period, 6);
        end
        check("score_saturated", score, 255);

        // Asynchronous reset in the middle of a scan.
        setup(40, 40, 50, 50, 48, -1);
        waited = 0;
        while (!direction_enable && waited < 100) begin
            step();
            waited++;
        end
        check("dir_latency_fast", waited, 5);
        repeat (3) step();
        check("mid_check_state", state, 3);
        repeat (2) step();
        check("mid_check_seg", seg_idx, 2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_score", score, 0);
        check("arst_period", step_period, 20);
        check("arst_seg_idx", seg_idx, 0);
        check("arst_game_over", game_over, 0);
        check("arst_food_eaten", food_eaten, 0);
        @(negedge slow_clk);
        rst = 1'b0;
        step();
        check("idle_after_arst", state, 0);
        alive = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (!alive) do_start(1'b0);
            run_move(tbl[i].hx, tbl[i].hy, tbl[i].fx, tbl[i].fy, tbl[i].size,
                     tbl[i].coll, tbl[i].dead, tbl[i].eat, tbl[i].chk);
        end

        for (int i = 0; i < 40; i++) begin
            if (!alive) do_start(1'b0);
            size = int'($urandom_range(2, 48));
            hx   = int'($urandom_range(0, 100));
            hy   = int'($urandom_range(0, 68));
            if ($urandom_range(0, 1) == 0) begin
                fx = hx; fy = hy;
            end else begin
                fx = int'($urandom_range(0, 95)); fy = int'($urandom_range(0, 63));
            end
            coll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, size - 2)) : -1;
            predict(hx, hy, fx, fy, size, coll, dead, eat, chk);
            run_move(hx, hy, fx, fy, size, coll, dead, eat, chk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
